// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - opcodes, alu_op encodings and sequencer state type
package control_pkg;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b000001;
    localparam logic [5:0] OP_AND = 6'b000010;
    localparam logic [5:0] OP_OR  = 6'b000011;
    localparam logic [5:0] OP_SLT = 6'b000100;
    localparam logic [5:0] OP_LW  = 6'b000101;
    localparam logic [5:0] OP_SW  = 6'b000110;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_FETCH  = S_FETCH,
        ST_DECODE = S_DECODE,
        ST_EXEC   = S_EXEC,
        ST_MEM    = S_MEM,
        ST_WB     = S_WB
    } ctrlState_t;

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - instruction/data memory request/ack handshake
interface multicycle_control_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (output imem_req, dmem_req, dmem_we, input imem_ack, dmem_ack);
    modport slave  (input imem_req, dmem_req, dmem_we, output imem_ack, dmem_ack);
endinterface

// File: rtl/multicycle_control_alu_op_decoder.sv
// rtl/multicycle_control_alu_op_decoder.sv - opcode to ALU control and instruction class
module alu_op_decoder
    import control_pkg::*;
(
    input  logic [5:0] op,
    output logic [2:0] aluOp,
    output logic       aluSrc,
    output logic       isLoad,
    output logic       isStore,
    output logic       illegal
);
    always_comb begin
        aluOp   = ALU_ADD;
        aluSrc  = 1'b0;
        isLoad  = 1'b0;
        isStore = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_ADD: aluOp = ALU_ADD;
            OP_SUB: aluOp = ALU_SUB;
            OP_AND: aluOp = ALU_AND;
            OP_OR:  aluOp = ALU_OR;
            OP_SLT: aluOp = ALU_SLT;
            OP_LW: begin
                aluSrc = 1'b1;
                isLoad = 1'b1;
            end
            OP_SW: begin
                aluSrc  = 1'b1;
                isStore = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU sequencer; RETIRE_COUNT_EN adds retired_count
module multicycle_control
    import control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] opcode,
    multicycle_control_if.master mem,
    output logic       ir_write,
    output logic       pc_write,
    output logic       alu_src,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       busy,
    output logic       retire,
    output logic       illegal_op,
    output logic       mem_error
`ifdef RETIRE_COUNT_EN
    ,
    output logic [31:0] retired_count
`endif
);
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

    ctrlState_t       state, stateNext;
    logic [5:0]       opQ, decIn;
    logic [2:0]       decAluOp;
    logic             decSrc, decLoad, decStore, decIllegal;
    logic [CNT_W-1:0] waitCnt;
    logic             memAck, waiting, timedOut, execLike;

    // The opcode is only valid during DECODE; later phases run off the captured copy.
    assign decIn = (state == ST_DECODE) ? opcode : opQ;

    alu_op_decoder u_dec (
        .op      (decIn),
        .aluOp   (decAluOp),
        .aluSrc  (decSrc),
        .isLoad  (decLoad),
        .isStore (decStore),
        .illegal (decIllegal)
    );

    assign memAck   = (state == ST_FETCH) ? mem.imem_ack : mem.dmem_ack;
    assign waiting  = ((state == ST_FETCH) || (state == ST_MEM)) && !memAck;
    assign timedOut = waiting && (MEM_TIMEOUT != 0) && (waitCnt == LIMIT);

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:   if (start) stateNext = ST_FETCH;
            ST_FETCH: begin
                if (mem.imem_ack)  stateNext = ST_DECODE;
                else if (timedOut) stateNext = ST_IDLE;
            end
            ST_DECODE: begin
                if (decIllegal) stateNext = start ? ST_FETCH : ST_IDLE;
                else            stateNext = ST_EXEC;
            end
            ST_EXEC:   stateNext = (decLoad || decStore) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (mem.dmem_ack)  stateNext = decStore ? (start ? ST_FETCH : ST_IDLE) : ST_WB;
                else if (timedOut) stateNext = ST_IDLE;
            end
            ST_WB:     stateNext = start ? ST_FETCH : ST_IDLE;
            default:   stateNext = ST_IDLE;
        endcase
    end

    // Any state change restarts the wait count, so FETCH and MEM always enter at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            opQ     <= '0;
            waitCnt <= '0;
        end else begin
            state <= stateNext;
            if (state == ST_DECODE) opQ <= opcode;
            if (stateNext != state)
                waitCnt <= '0;
            else if (waiting && (MEM_TIMEOUT != 0))
                waitCnt <= waitCnt + 1'b1;
        end
    end

    assign execLike     = (state == ST_EXEC) || (state == ST_MEM);
    assign busy         = (state != ST_IDLE);
    assign mem.imem_req = (state == ST_FETCH);
    assign ir_write     = (state == ST_FETCH) && mem.imem_ack;
    assign pc_write     = (state == ST_FETCH) && mem.imem_ack;
    assign mem.dmem_req = (state == ST_MEM);
    assign mem.dmem_we  = (state == ST_MEM) && decStore;
    assign alu_src      = execLike && decSrc;
    assign alu_op       = (execLike || (state == ST_WB)) ? decAluOp : 3'b000;
    assign reg_write    = (state == ST_WB);
    assign mem_to_reg   = (state == ST_WB) && decLoad;
    assign retire       = (state == ST_WB) || ((state == ST_MEM) && decStore && mem.dmem_ack);
    assign illegal_op   = (state == ST_DECODE) && decIllegal;
    assign mem_error    = timedOut;

`ifdef RETIRE_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      retired_count <= '0;
        else if (retire) retired_count <= retired_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;
    localparam int TO = 15;

    localparam logic [14:0] IREQ = 15'h4000, IRW = 15'h2000, PCW = 15'h1000;
    localparam logic [14:0] DREQ = 15'h0800, DWE = 15'h0400, SRC = 15'h0200;
    localparam logic [14:0] RW = 15'h0020, M2R = 15'h0010, BSY = 15'h0008;
    localparam logic [14:0] RET = 15'h0004, ILL = 15'h0002, ERR = 15'h0001;

    logic       clk = 1'b0;
    logic       rst_n, start;
    logic [5:0] opcode;
    logic       ir_write, pc_write, alu_src, reg_write, mem_to_reg;
    logic       busy, retire, illegal_op, mem_error;
    logic [2:0] alu_op;
`ifdef RETIRE_COUNT_EN
    logic [31:0] retired_count;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expRetired = 0;
    logic [2:0]  aluTab [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0};

    multicycle_control_if memBus ();

    multicycle_control #(.MEM_TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .opcode     (opcode),
        .mem        (memBus),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .busy       (busy),
        .retire     (retire),
        .illegal_op (illegal_op),
        .mem_error  (mem_error)
`ifdef RETIRE_COUNT_EN
        ,
        .retired_count (retired_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] observed();
        return {memBus.imem_req, ir_write, pc_write, memBus.dmem_req, memBus.dmem_we,
                alu_src, alu_op, reg_write, mem_to_reg, busy, retire, illegal_op, mem_error};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    task automatic check(input logic [14:0] obs, input logic [14:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkCount(input string tag);
`ifdef RETIRE_COUNT_EN
        checks++;
        assert (retired_count === expRetired) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, retired_count, expRetired);
        end
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    // One clock cycle: drive inputs after the falling edge, compare settled outputs 1ns later.
    task automatic tick(input logic st, input logic ia, input logic da, input logic [5:0] op,
                        input logic [14:0] exp, input string tag);
        @(negedge clk);
        start = st;
        memBus.imem_ack = ia;
        memBus.dmem_ack = da;
        opcode = op;
        #1;
        check(observed(), exp, tag);
        checkCount({tag, "_count"});
        if (exp[2]) expRetired++;
    endtask

    task automatic doReset(input logic st);
        rst_n = 1'b0;
        #1;
        check(observed(), 15'h0, "reset_async");
        expRetired = 0;
        checkCount("reset_count");
        @(negedge clk);
        rst_n = 1'b1;
        start = st;
        memBus.imem_ack = 1'b0;
        memBus.dmem_ack = 1'b0;
        #1;
        check(observed(), 15'h0, "idle_after_reset");
    endtask

    // Wait counts above TO mean "never acknowledged"; the run then ends in a timeout.
    task automatic runInstr(input logic [5:0] op, input int fWait, input int mWait, input logic keep);
        logic        legal, isLw, isSw;
        logic [14:0] alu;
        legal = (op < 6'd7);
        isLw  = (op == 6'd5);
        isSw  = (op == 6'd6);
        alu   = legal ? {6'd0, aluTab[op], 6'd0} : 15'h0;
        if (fWait > TO) begin
            for (int i = 0; i < TO; i++) tick(1'b1, 1'b0, rb(), rop(), BSY | IREQ, "fetch_wait");
            tick(1'b1, 1'b0, rb(), rop(), BSY | IREQ | ERR, "fetch_timeout");
            tick(1'b1, rb(), rb(), rop(), 15'h0, "idle_after_err");
            return;
        end
        for (int i = 0; i < fWait; i++) tick(1'b1, 1'b0, rb(), rop(), BSY | IREQ, "fetch_wait");
        tick(1'b1, 1'b1, rb(), rop(), BSY | IREQ | IRW | PCW, "fetch_ack");
        if (!legal) begin
            tick(keep, rb(), rb(), op, BSY | ILL, "decode_illegal");
        end else begin
            tick(keep, rb(), rb(), op, BSY, "decode");
            tick(keep, rb(), rb(), rop(), BSY | alu | ((isLw || isSw) ? SRC : 15'h0), "exec");
            if (isLw || isSw) begin
                for (int i = 0; i < ((mWait > TO) ? TO : mWait); i++)
                    tick(keep, rb(), 1'b0, rop(), BSY | alu | SRC | DREQ | (isSw ? DWE : 15'h0), "mem_wait");
                if (mWait > TO) begin
                    tick(keep, rb(), 1'b0, rop(), BSY | alu | SRC | DREQ | (isSw ? DWE : 15'h0) | ERR, "mem_timeout");
                    tick(1'b1, rb(), rb(), rop(), 15'h0, "idle_after_err");
                    return;
                end
                tick(keep, rb(), 1'b1, rop(), BSY | alu | SRC | DREQ | (isSw ? (DWE | RET) : 15'h0), "mem_ack");
            end
            if (!isSw) tick(keep, rb(), rb(), rop(), BSY | alu | RW | RET | (isLw ? M2R : 15'h0), "wb");
        end
        if (!keep) begin
            tick(1'b0, rb(), rb(), rop(), 15'h0, "idle_hold");
            tick(1'b1, rb(), rb(), rop(), 15'h0, "idle_restart");
        end
    endtask

    initial begin
        logic [5:0] op;
        int         r;
        rst_n = 1'b1;
        start = 1'b0;
        opcode = '0;
        memBus.imem_ack = 1'b0;
        memBus.dmem_ack = 1'b0;
        #1;
        doReset(1'b1);

        runInstr(6'd0, 0, 0, 1'b1);
        runInstr(6'd5, 0, 3, 1'b1);
        runInstr(6'd6, 0, 1, 1'b1);
        runInstr(6'd63, 0, 0, 1'b1);
        runInstr(6'd1, 14, 0, 1'b1);
        runInstr(6'd4, TO, 0, 1'b1);
        runInstr(6'd2, TO + 1, 0, 1'b1);
        runInstr(6'd5, 0, TO + 1, 1'b1);
        runInstr(6'd6, 0, TO, 1'b1);
        runInstr(6'd3, 2, 0, 1'b0);
        runInstr(6'd9, 0, 0, 1'b0);

        // Reset while a load is waiting in MEM.
        tick(1'b1, 1'b1, 1'b0, rop(), BSY | IREQ | IRW | PCW, "fetch_ack");
        tick(1'b1, 1'b0, 1'b0, 6'd5, BSY, "decode");
        tick(1'b1, 1'b0, 1'b0, rop(), BSY | SRC, "exec");
        tick(1'b1, 1'b0, 1'b0, rop(), BSY | SRC | DREQ, "mem_wait");
        doReset(1'b1);

        runInstr(6'd0, 0, 0, 1'b1);
        runInstr(6'd6, 1, 0, 1'b1);
        runInstr(6'd5, 0, 2, 1'b1);
        tick(1'b1, 1'b0, 1'b0, rop(), BSY | IREQ, "fetch_wait");
        doReset(1'b1);

        for (int n = 0; n < 300; n++) begin
            r  = $urandom_range(0, 9);
            op = (r < 7) ? 6'(r) : 6'($urandom_range(7, 63));
            runInstr(op, ($urandom_range(0, 19) == 0) ? TO + 1 : $urandom_range(0, 3) == 0 ? $urandom_range(0, TO) : 0,
                     ($urandom_range(0, 19) == 0) ? TO + 1 : $urandom_range(0, TO),
                     ($urandom_range(0, 4) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
